// File: rtl/multicycle_sequencer.sv
// ---------------------------------------------------------------------------
// multicycle_sequencer
//   Multi-cycle control sequencer for the core. Owns the program counter and
//   the instruction register, and steps each instruction through
//   FETCH -> EXEC -> [MEM] -> WB. Data-memory accesses use a req/ack handshake
//   with a bounded wait; a missing ack sends the machine to ERR. Retiring the
//   instruction at HALT_ADDR stops the run in HALT.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-low reset
//   start      in   begin a run (honoured only in IDLE / HALT / ERR)
//   mach_code  in   instruction word from instr_ROM at prog_ctr
//   is_load    in   decoder: latched instruction is a load
//   is_store   in   decoder: latched instruction is a store
//   is_branch  in   decoder: latched instruction is a branch
//   reg_write  in   decoder: latched instruction writes reg_file
//   branch_pc  in   ALU: branch condition true
//   target     in   PC_LUT branch target
//   mem_ack    in   data memory access complete (one-cycle pulse)
//   prog_ctr   out  program counter
//   instr      out  instruction register
//   state      out  FSM state encoding (debug)
//   mem_req    out  data memory request, held until ack
//   mem_we     out  store qualifier, valid with mem_req
//   rf_wr_en   out  reg_file write strobe (one cycle, in WB)
//   busy       out  high in FETCH/EXEC/MEM/WB
//   done       out  high in HALT
//   err        out  high in ERR (memory timeout)
//   cyc_cnt    out  busy cycles since start, saturating
//   ret_cnt    out  instructions retired, saturating
// ---------------------------------------------------------------------------
module multicycle_sequencer #(
    parameter int D         = 10,
    parameter int IW        = 9,
    parameter int RESET_PC  = 0,
    parameter int HALT_ADDR = 381,
    parameter int MAX_WAIT  = 15,
    parameter int CW        = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [IW-1:0] mach_code,
    input  logic          is_load,
    input  logic          is_store,
    input  logic          is_branch,
    input  logic          reg_write,
    input  logic          branch_pc,
    input  logic [D-1:0]  target,
    input  logic          mem_ack,
    output logic [D-1:0]  prog_ctr,
    output logic [IW-1:0] instr,
    output logic [2:0]    state,
    output logic          mem_req,
    output logic          mem_we,
    output logic          rf_wr_en,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [CW-1:0] cyc_cnt,
    output logic [CW-1:0] ret_cnt
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_MEM   = 3'd3,
        S_WB    = 3'd4,
        S_HALT  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    localparam int            WW      = $clog2(MAX_WAIT + 1);
    localparam logic [D-1:0]  RST_PC  = D'(RESET_PC);
    localparam logic [D-1:0]  HALT_PC = D'(HALT_ADDR);
    localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);
    localparam logic [CW-1:0] CNT_MAX = '1;

    state_t        state_q;
    logic [D-1:0]  pc_q;
    logic [D-1:0]  pc_d;
    logic [IW-1:0] instr_q;
    logic [WW-1:0] wait_q;
    logic          req_q;
    logic          we_q;
    logic          wr_q;
    logic [CW-1:0] cyc_q;
    logic [CW-1:0] ret_q;
    logic          busy_w;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    assign busy_w = (state_q == S_FETCH) || (state_q == S_EXEC) ||
                    (state_q == S_MEM)   || (state_q == S_WB);

    // Successor PC, only consumed in WB; the +1 wraps modulo 2**D.
    always_comb begin
        pc_d = pc_q + 1'b1;
        if (is_branch && branch_pc) pc_d = target;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pc_q    <= RST_PC;
            instr_q <= '0;
            wait_q  <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            wr_q    <= 1'b0;
            cyc_q   <= '0;
            ret_q   <= '0;
        end else begin
            if (busy_w) cyc_q <= sat_inc(cyc_q);
            case (state_q)
                S_IDLE, S_HALT, S_ERR: begin
                    if (start) begin
                        state_q <= S_FETCH;
                        pc_q    <= RST_PC;
                        cyc_q   <= '0;
                        ret_q   <= '0;
                    end
                end
                S_FETCH: begin
                    instr_q <= mach_code;
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    if (is_load || is_store) begin
                        state_q <= S_MEM;
                        req_q   <= 1'b1;
                        we_q    <= is_store;
                        wait_q  <= '0;
                    end else begin
                        state_q <= S_WB;
                        wr_q    <= reg_write & ~is_store;
                    end
                end
                S_MEM: begin
                    if (mem_ack) begin
                        state_q <= S_WB;
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        wr_q    <= reg_write & ~is_store;
                    end else if (wait_q == WAIT_LAST) begin
                        // Timeout: request is withdrawn as ERR is entered.
                        state_q <= S_ERR;
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                S_WB: begin
                    wr_q  <= 1'b0;
                    ret_q <= sat_inc(ret_q);
                    // The halt instruction still retires, but the PC stays on it.
                    if (pc_q == HALT_PC) begin
                        state_q <= S_HALT;
                    end else begin
                        pc_q    <= pc_d;
                        state_q <= S_FETCH;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign prog_ctr = pc_q;
    assign instr    = instr_q;
    assign state    = state_q;
    assign mem_req  = req_q;
    assign mem_we   = we_q;
    assign rf_wr_en = wr_q;
    assign busy     = busy_w;
    assign done     = (state_q == S_HALT);
    assign err      = (state_q == S_ERR);
    assign cyc_cnt  = cyc_q;
    assign ret_cnt  = ret_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
module tb_multicycle_sequencer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, start4;
    logic [8:0]  mach_code;
    logic        is_load, is_store, is_branch, reg_write, branch_pc, mem_ack;
    logic [9:0]  target;
    logic [3:0]  target4;

    logic [9:0]  prog_ctr;
    logic [8:0]  instr;
    logic [2:0]  state;
    logic        mem_req, mem_we, rf_wr_en, busy, done, err;
    logic [15:0] cyc_cnt, ret_cnt;

    logic [3:0]  prog_ctr4;
    logic [8:0]  instr4;
    logic [2:0]  state4;
    logic        mem_req4, mem_we4, rf_wr_en4, busy4, done4, err4;
    logic [15:0] cyc_cnt4, ret_cnt4;

    multicycle_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .mach_code(mach_code),
        .is_load(is_load), .is_store(is_store), .is_branch(is_branch),
        .reg_write(reg_write), .branch_pc(branch_pc), .target(target),
        .mem_ack(mem_ack), .prog_ctr(prog_ctr), .instr(instr), .state(state),
        .mem_req(mem_req), .mem_we(mem_we), .rf_wr_en(rf_wr_en), .busy(busy),
        .done(done), .err(err), .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt)
    );

    multicycle_sequencer #(.D(4), .HALT_ADDR(9)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .mach_code(mach_code),
        .is_load(is_load), .is_store(is_store), .is_branch(is_branch),
        .reg_write(reg_write), .branch_pc(branch_pc), .target(target4),
        .mem_ack(mem_ack), .prog_ctr(prog_ctr4), .instr(instr4), .state(state4),
        .mem_req(mem_req4), .mem_we(mem_we4), .rf_wr_en(rf_wr_en4), .busy(busy4),
        .done(done4), .err(err4), .cyc_cnt(cyc_cnt4), .ret_cnt(ret_cnt4)
    );

    typedef struct {
        logic [9:0] pc;
        logic       wr;
    } exp_t;

    exp_t        sb[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    logic [9:0]  mpc;
    int          mret;
    int          reqs;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [8:0] mc_of(input logic [9:0] pc);
        return pc[8:0] ^ 9'h0A5;
    endfunction

    // Retire monitor: every WB cycle consumes one scoreboard entry.
    always @(negedge clk) begin
        if (state == 3'd4) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("wb_pc", prog_ctr, e.pc);
                check("wb_rf_wr_en", rf_wr_en, e.wr);
            end
        end else if (rf_wr_en) begin
            check("rf_wr_en_outside_wb", rf_wr_en, 32'd0);
        end
    end

    task automatic clear_dec();
        is_load = 0; is_store = 0; is_branch = 0; reg_write = 0; branch_pc = 0;
    endtask

    task automatic do_start();
        start = 1;
        @(negedge clk);
        start = 0;
        mpc = 10'd0;
        mret = 0;
        check("start_state", state, 32'd1);
        check("start_pc", prog_ctr, 32'd0);
        check("start_cyc", cyc_cnt, 32'd0);
        check("start_ret", ret_cnt, 32'd0);
    endtask

    // Entered at a negedge with the DUT in FETCH; leaves at the negedge after WB.
    task automatic run(input bit ld, input bit st, input bit br, input bit bpc, input bit rw,
                       input logic [9:0] tgt, input int k, output int req_cycles);
        logic [9:0] nxt;
        bit         halting;
        check("fetch_state", state, 32'd1);
        is_load = ld; is_store = st; is_branch = br; branch_pc = bpc; reg_write = rw;
        target = tgt;
        mach_code = mc_of(mpc);
        sb.push_back('{pc: mpc, wr: rw & ~st});
        @(negedge clk);
        check("exec_state", state, 32'd2);
        check("instr", instr, mc_of(mpc));
        req_cycles = 0;
        if (ld || st) begin
            for (int i = 0; i <= k; i++) begin
                @(negedge clk);
                check("mem_req", mem_req, 32'd1);
                check("mem_we", mem_we, st);
                req_cycles++;
                if (i == k) mem_ack = 1;
            end
            @(negedge clk);
            mem_ack = 0;
            check("req_after_ack", mem_req, 32'd0);
        end else begin
            @(negedge clk);
        end
        halting = (mpc == 10'd381);
        nxt = (br && bpc) ? tgt : mpc + 10'd1;
        mret++;
        @(negedge clk);
        if (halting) begin
            check("halt_state", state, 32'd5);
            check("halt_done", done, 32'd1);
            check("halt_pc", prog_ctr, 32'd381);
        end else begin
            mpc = nxt;
            check("next_state", state, 32'd1);
            check("next_pc", prog_ctr, mpc);
        end
        check("ret_cnt", ret_cnt, mret);
        clear_dec();
    endtask

    initial begin
        reset = 0; start = 0; start4 = 0; mem_ack = 0;
        mach_code = '0; target = '0; target4 = '0;
        clear_dec();
        mpc = 0; mret = 0;
        repeat (2) @(negedge clk);
        check("rst_state", state, 32'd0);
        check("rst_pc", prog_ctr, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_flags", {busy, done, err, mem_req, mem_we, rf_wr_en}, 32'd0);
        reset = 1;
        @(negedge clk);
        check("idle_hold", state, 32'd0);

        // Reset asserted mid-MEM clears everything without waiting for a clock.
        do_start();
        is_load = 1; reg_write = 1; mach_code = mc_of(10'd0);
        @(negedge clk);
        @(negedge clk);
        check("midrun_req", mem_req, 32'd1);
        #2 reset = 0;
        #1;
        check("async_state", state, 32'd0);
        check("async_req", mem_req, 32'd0);
        check("async_pc", prog_ctr, 32'd0);
        check("async_instr", instr, 32'd0);
        check("async_cnt", {cyc_cnt, ret_cnt}, 32'd0);
        check("async_flags", {busy, done, err, rf_wr_en}, 32'd0);
        clear_dec();
        @(negedge clk);
        reset = 1;
        @(negedge clk);

        // Three ALU ops: 3 cycles each.
        do_start();
        for (int i = 0; i < 3; i++) run(0, 0, 0, 0, 1, 10'd0, 0, reqs);
        check("alu_cyc", cyc_cnt, 32'd9);
        check("alu_ret", ret_cnt, 32'd3);

        // Load with two extra wait cycles, then a store acked at once.
        run(1, 0, 0, 0, 1, 10'd0, 2, reqs);
        check("load_req_cycles", reqs, 32'd3);
        check("load_cyc", cyc_cnt, 32'd9 + 32'd6);
        run(0, 1, 0, 0, 1, 10'd0, 0, reqs);
        check("store_req_cycles", reqs, 32'd1);
        check("store_pc", prog_ctr, 32'd5);

        // Branches from PC=5.
        run(0, 0, 1, 1, 0, 10'd200, 0, reqs);
        run(0, 0, 1, 1, 0, 10'd5, 0, reqs);
        run(0, 0, 1, 0, 0, 10'd200, 0, reqs);
        check("not_taken_pc", prog_ctr, 32'd6);

        // Wrap at the top of the 10-bit PC range.
        run(0, 0, 1, 1, 0, 10'd1023, 0, reqs);
        run(0, 0, 0, 0, 1, 10'd0, 0, reqs);
        check("wrap10_pc", prog_ctr, 32'd0);

        // Halt at 381.
        run(0, 0, 1, 1, 0, 10'd381, 0, reqs);
        run(0, 0, 0, 0, 1, 10'd0, 0, reqs);
        mem_ack = 1;
        repeat (3) @(negedge clk);
        mem_ack = 0;
        check("halt_frozen_pc", prog_ctr, 32'd381);
        check("halt_frozen_flags", {done, busy, err, mem_req}, 32'b1000);

        // Memory timeout: 15 MEM cycles without ack.
        do_start();
        is_load = 1; reg_write = 1; mach_code = mc_of(10'd0);
        @(negedge clk);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check("to_req", mem_req, 32'd1);
        end
        @(negedge clk);
        check("to_err", err, 32'd1);
        check("to_state", state, 32'd6);
        check("to_req_drop", mem_req, 32'd0);
        check("to_ret", ret_cnt, 32'd0);
        clear_dec();
        @(negedge clk);
        check("err_hold", err, 32'd1);

        // D=4 instance: branch to 15, then an ALU op wraps to 0.
        start4 = 1;
        @(negedge clk);
        start4 = 0;
        check("d4_start", state4, 32'd1);
        is_branch = 1; branch_pc = 1; target4 = 4'd15;
        repeat (3) @(negedge clk);
        check("d4_pc15", prog_ctr4, 32'd15);
        clear_dec();
        repeat (3) @(negedge clk);
        check("d4_wrap", prog_ctr4, 32'd0);
        check("d4_ret", ret_cnt4, 32'd2);

        // Restart out of ERR.
        do_start();
        run(0, 0, 0, 0, 1, 10'd0, 0, reqs);
        check("restart_pc", prog_ctr, 32'd1);

        check("sb_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
